led_step_ctrl: RTL

//   Upstream control stage for the 4-LED chaser. Debounces two raw push-buttons (speed, pause).

---
 rtl/led_step_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/led_step_ctrl.sv
// Step-rate controller for the 4-LED chaser: debounced speed/pause buttons,
// selectable step period and run/pause, producing a registered one-cycle step pulse.
module led_step_ctrl #(
    parameter int BASE_PERIOD     = 25000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 25,
    parameter int DB_W            = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_speed,
    input  logic       btn_pause,
    output logic       step,
    output logic [1:0] speed_lvl,
    output logic       running
);

    localparam int BTN_SPEED = 0;
    localparam int BTN_PAUSE = 1;

    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_0  = CNT_W'((BASE_PERIOD >> 0) - 1);
    localparam logic [CNT_W-1:0] LAST_1  = CNT_W'((BASE_PERIOD >> 1) - 1);
    localparam logic [CNT_W-1:0] LAST_2  = CNT_W'((BASE_PERIOD >> 2) - 1);
    localparam logic [CNT_W-1:0] LAST_3  = CNT_W'((BASE_PERIOD >> 3) - 1);

    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      stable_q, stable_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [1:0]      press_s;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_s;
    logic [1:0]       lvl_q, lvl_d;
    logic             run_q, run_d;
    logic             step_q, step_d;

    // Debounce both synced buttons; a press is the cycle the stable level is accepted as 1.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            press_s[i]  = 1'b0;
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
                press_s[i]  = sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Terminal count for the current speed level (period halves per level).
    always_comb begin
        case (lvl_q)
            2'd0:    last_s = LAST_0;
            2'd1:    last_s = LAST_1;
            2'd2:    last_s = LAST_2;
            2'd3:    last_s = LAST_3;
            default: last_s = LAST_0;
        endcase
    end

    // Period counter, speed level and run state; a pause event freezes the counter on its edge.
    always_comb begin
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        run_d  = run_q;
        step_d = 1'b0;
        if (press_s[BTN_PAUSE]) begin
            run_d = ~run_q;
        end else begin
            run_d = run_q;
        end
        if (press_s[BTN_SPEED]) begin
            lvl_d = lvl_q + 2'd1;
            cnt_d = '0;
        end else if (press_s[BTN_PAUSE] || !run_q) begin
            cnt_d = cnt_q;
        end else if (cnt_q == last_s) begin
            cnt_d  = '0;
            step_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            stable_q    <= 2'b00;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            cnt_q       <= '0;
            lvl_q       <= 2'd0;
            run_q       <= 1'b1;
            step_q      <= 1'b0;
        end else begin
            sync1_q     <= {btn_pause, btn_speed};
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            cnt_q       <= cnt_d;
            lvl_q       <= lvl_d;
            run_q       <= run_d;
            step_q      <= step_d;
        end
    end

    assign step      = step_q;
    assign speed_lvl = lvl_q;
    assign running   = run_q;

endmodule
